// File: rtl/rx_frame_fifo_pkg.sv
// Shared types for the receive frame buffer.
package rx_frame_fifo_pkg;

  typedef enum logic {
    WR_STORE = 1'b0,
    WR_DROP  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/rx_frame_fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset on the array.
module sdp_ram #(
  parameter int unsigned WIDTH      = 37,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward receive buffer: only frames ending with tuser=0 are released;
// errored or non-fitting frames are discarded whole by rolling back the write pointer.
module rx_frame_fifo
  import rx_frame_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned ADDR_WIDTH  = 9,
  localparam int unsigned DATA_NBYTES = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  s00_axis_tdata,
  input  logic [DATA_NBYTES-1:0] s00_axis_tkeep,
  input  logic                   s00_axis_tvalid,
  input  logic                   s00_axis_tlast,
  input  logic                   s00_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m00_axis_tdata,
  output logic [DATA_NBYTES-1:0] m00_axis_tkeep,
  output logic                   m00_axis_tvalid,
  input  logic                   m00_axis_tready,
  output logic                   m00_axis_tlast,
  output logic [15:0]            bad_frame_count,
  output logic [15:0]            overflow_count
);

  localparam int unsigned        ENTRY_W = DATA_WIDTH + DATA_NBYTES + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};

  wr_state_t             r_state;
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_commit_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [15:0]           r_bad_cnt;
  logic [15:0]           r_ovf_cnt;
  logic                  r_pend;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_NBYTES-1:0] r_out_keep;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic                  w_full;
  logic                  w_wr_en;
  logic                  w_out_free;
  logic                  w_rd_en;
  logic [ENTRY_W-1:0]    w_rd_entry;

  assign w_full     = (r_wr_ptr - r_rd_ptr) == DEPTH;
  assign w_wr_en    = s00_axis_tvalid && (r_state == WR_STORE) && !w_full;
  assign w_out_free = !r_out_valid || m00_axis_tready;
  // The RAM output register is a pipeline slot: only read when it will be drained this edge.
  assign w_rd_en    = (r_rd_ptr != r_commit_ptr) && (!r_pend || w_out_free);

  sdp_ram #(
    .WIDTH      (ENTRY_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata ({s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata}),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= WR_STORE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_bad_cnt    <= '0;
      r_ovf_cnt    <= '0;
    end else begin
      case (r_state)
        WR_STORE: begin
          if (s00_axis_tvalid) begin
            if (!w_full) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              if (s00_axis_tlast && !s00_axis_tuser) begin
                r_commit_ptr <= r_wr_ptr + 1'b1;
              end else if (s00_axis_tlast) begin
                r_wr_ptr <= r_commit_ptr;
                if (r_bad_cnt != '1) r_bad_cnt <= r_bad_cnt + 1'b1;
              end
            end else begin
              r_wr_ptr <= r_commit_ptr;
              if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
              if (!s00_axis_tlast) r_state <= WR_DROP;
            end
          end
        end
        WR_DROP: begin
          if (s00_axis_tvalid && s00_axis_tlast) r_state <= WR_STORE;
        end
        default: r_state <= WR_STORE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_keep  <= '0;
      r_out_data  <= '0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_out_free) begin
        r_out_valid <= r_pend;
        if (r_pend) {r_out_last, r_out_keep, r_out_data} <= w_rd_entry;
      end
      r_pend <= w_rd_en || (r_pend && !w_out_free);
    end
  end

  assign m00_axis_tdata  = r_out_data;
  assign m00_axis_tkeep  = r_out_keep;
  assign m00_axis_tvalid = r_out_valid;
  assign m00_axis_tlast  = r_out_last;
  assign bad_frame_count = r_bad_cnt;
  assign overflow_count  = r_ovf_cnt;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed bench for rx_frame_fifo at depth 16: good/bad/overflow frames, backpressure, wrap, reset.
module tb_rx_frame_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_user = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_tready = 1'b1;
  logic        m_last;
  logic [15:0] bad_cnt;
  logic [15:0] ovf_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [36:0] exp_q[$];
  int          rdy_mode = 0;
  logic        rdy_fixed = 1'b1;
  int          exp_bad = 0;
  logic        prev_stall = 1'b0;
  logic [37:0] held = '0;

  always #5 clk = ~clk;

  rx_frame_fifo #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4)
  ) dut (
    .clk             (clk),
    .reset           (rst),
    .s00_axis_tdata  (s_data),
    .s00_axis_tkeep  (s_keep),
    .s00_axis_tvalid (s_valid),
    .s00_axis_tlast  (s_last),
    .s00_axis_tuser  (s_user),
    .m00_axis_tdata  (m_data),
    .m00_axis_tkeep  (m_keep),
    .m00_axis_tvalid (m_valid),
    .m00_axis_tready (m_tready),
    .m00_axis_tlast  (m_last),
    .bad_frame_count (bad_cnt),
    .overflow_count  (ovf_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tready pattern: fixed, toggling, or random (2/3 ready)
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       m_tready = rdy_fixed;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Output monitor: transfers and stall stability judged at the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 64'({m_valid, m_last, m_keep, m_data}), 64'(held));
      if (m_valid && m_tready) begin
        n_checks++;
        assert (exp_q.size() > 0) else begin
          n_errors++;
          $error("FAIL extra_beat: observed=%0h expected=no_beat", {m_last, m_keep, m_data});
        end
        if (exp_q.size() > 0) chk("beat", 64'({m_last, m_keep, m_data}), 64'(exp_q.pop_front()));
      end
      prev_stall = m_valid && !m_tready;
      held = {m_valid, m_last, m_keep, m_data};
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int len, input bit user, input logic [3:0] lkeep, input bit expect_out);
    for (int i = 0; i < len; i++) begin
      s_data  = $urandom;
      s_last  = (i == len - 1);
      s_keep  = s_last ? lkeep : 4'hF;
      s_user  = s_last ? user : 1'($urandom_range(0, 1));
      s_valid = 1'b1;
      if (expect_out) exp_q.push_back({s_last, s_keep, s_data});
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_user  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_room(input int len);
    int cyc;
    cyc = 0;
    while (exp_q.size() + len > DEPTH && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("room_wait", 64'(exp_q.size() + len > DEPTH), 64'd0);
  endtask

  initial begin
    logic [3:0] kt [4];
    int         len;
    bit         user;
    kt = '{4'h1, 4'h3, 4'h7, 4'hF};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_keep", 64'(m_keep), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_bad", 64'(bad_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);
    rst = 1'b0;
    idle(2);

    // Good 16-word frame and tlast-to-tvalid latency
    send_frame(16, 1'b0, 4'b0011, 1'b1);
    chk("lat_k", 64'(m_valid), 64'd0);
    idle(1);
    chk("lat_k1", 64'(m_valid), 64'd0);
    idle(1);
    chk("lat_k2", 64'(m_valid), 64'd1);
    drain("good_drain");

    // Errored frame followed by a short good frame
    send_frame(16, 1'b1, 4'hF, 1'b0);
    send_frame(4, 1'b0, 4'b0001, 1'b1);
    drain("bad_drain");
    chk("bad_cnt1", 64'(bad_cnt), 64'd1);
    chk("ovf_cnt0", 64'(ovf_cnt), 64'd0);

    // Oversized frame dropped whole, then a fitting frame
    rdy_fixed = 1'b0;
    idle(2);
    send_frame(20, 1'b0, 4'hF, 1'b0);
    idle(4);
    chk("ovf_no_out", 64'(m_valid), 64'd0);
    chk("ovf_cnt1", 64'(ovf_cnt), 64'd1);
    rdy_fixed = 1'b1;
    send_frame(8, 1'b0, 4'b0111, 1'b1);
    drain("ovf_drain");
    chk("ovf_cnt_hold", 64'(ovf_cnt), 64'd1);

    // Back-to-back frames with toggling tready
    rdy_mode = 1;
    send_frame(5, 1'b0, 4'hF, 1'b1);
    send_frame(6, 1'b0, 4'h3, 1'b1);
    send_frame(4, 1'b0, 4'h1, 1'b1);
    drain("bp_drain");

    // Random lengths, errors and tready across many pointer wraps
    rdy_mode = 2;
    exp_bad  = 1;
    for (int f = 0; f < 100; f++) begin
      len  = int'($urandom_range(1, 16));
      user = ($urandom_range(0, 3) == 0);
      wait_room(len);
      send_frame(len, user, kt[$urandom_range(0, 3)], !user);
      if (user) exp_bad++;
    end
    drain("wrap_drain");
    chk("wrap_bad", 64'(bad_cnt), 64'(exp_bad));
    chk("wrap_ovf", 64'(ovf_cnt), 64'd1);

    // Reset during a frame while a committed frame is stalled at the output
    rdy_mode  = 0;
    rdy_fixed = 1'b0;
    idle(2);
    send_frame(3, 1'b0, 4'hF, 1'b1);
    idle(3);
    chk("pre_rst_valid", 64'(m_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      s_data  = 32'hA000_0000 + 32'(i);
      s_keep  = 4'hF;
      s_last  = 1'b0;
      s_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    s_data = 32'hA000_0004;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", 64'(m_valid), 64'd0);
    chk("rst_mid_bad", 64'(bad_cnt), 64'd0);
    chk("rst_mid_ovf", 64'(ovf_cnt), 64'd0);
    rst     = 1'b0;
    s_valid = 1'b0;
    exp_q.delete();
    rdy_fixed = 1'b1;
    idle(2);
    send_frame(3, 1'b0, 4'h7, 1'b1);
    drain("post_rst_drain");
    idle(3);
    chk("post_rst_idle", 64'(m_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
